// File: rtl/tb_cmd_dispatcher_if.sv
// Command handshake bundle for the scenario dispatcher.
// master drives valid/id/timeout; slave returns ready.
interface tb_cmd_dispatcher_if #(
  parameter int ID_W      = 3,
  parameter int TIMEOUT_W = 16
);
  logic                 i_cmd_valid;
  logic [ID_W-1:0]      i_cmd_id;
  logic [TIMEOUT_W-1:0] i_cmd_timeout;
  logic                 o_cmd_ready;

  modport master (
    output i_cmd_valid,
    output i_cmd_id,
    output i_cmd_timeout,
    input  o_cmd_ready
  );

  modport slave (
    input  i_cmd_valid,
    input  i_cmd_id,
    input  i_cmd_timeout,
    output o_cmd_ready
  );
endinterface

// File: rtl/tb_cmd_dispatcher.sv
// One-at-a-time command dispatcher: one-hot channel select,
// done/abort/timeout wait, single-cycle ack with status/elapsed.
// Ports: clk, rst_n, cmd (slave handshake), i_done, i_abort,
// o_sel, o_ack, o_status, o_elapsed, o_cmd_cnt.
module tb_cmd_dispatcher #(
  parameter int                CMD_NB        = 4,
  parameter int                ID_W          = 3,
  parameter int                TIMEOUT_W     = 16,
  parameter logic [CMD_NB-1:0] BLOCKING_MASK = 4'b1010,
  parameter int                CNT_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tb_cmd_dispatcher_if.slave   cmd,
  input  logic [CMD_NB-1:0]    i_done,
  input  logic                 i_abort,
  output logic [CMD_NB-1:0]    o_sel,
  output logic                 o_ack,
  output logic [1:0]           o_status,
  output logic [TIMEOUT_W-1:0] o_elapsed,
  output logic [CNT_W-1:0]     o_cmd_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_ACK
  } state_e;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_TMO   = 2'b01;
  localparam logic [1:0] ST_ABORT = 2'b10;
  localparam logic [1:0] ST_UNK   = 2'b11;

  localparam logic [ID_W-1:0]   NB_ID = ID_W'(CMD_NB);
  localparam logic [CMD_NB-1:0] ONE   = CMD_NB'(1);

  state_e state_q, state_d;

  logic [CMD_NB-1:0]    sel_q;
  logic [TIMEOUT_W-1:0] tmo_q;
  logic [TIMEOUT_W-1:0] elapsed_q;
  logic                 unk_q;
  logic                 ack_q;
  logic [1:0]           status_q;
  logic [TIMEOUT_W-1:0] oel_q;
  logic [CNT_W-1:0]     cnt_q;

  logic                 accept;
  logic                 id_unk;
  logic [CMD_NB-1:0]    id_sel;
  logic                 blk;
  logic                 hit;
  logic [TIMEOUT_W-1:0] el_inc;
  logic                 fin;
  logic [1:0]           fin_st;

  assign cmd.o_cmd_ready = (state_q == S_IDLE);
  assign accept = cmd.i_cmd_valid
                & (state_q == S_IDLE);

  assign id_unk = (cmd.i_cmd_id >= NB_ID);
  assign id_sel = id_unk ? '0
                         : ONE << cmd.i_cmd_id;

  // The latched select doubles as the decoded id.
  assign blk = |(sel_q & BLOCKING_MASK);
  assign hit = |(sel_q & i_done);

  assign el_inc = (&elapsed_q) ? elapsed_q
                               : elapsed_q + 1'b1;

  always_comb begin
    state_d = state_q;
    fin     = 1'b0;
    fin_st  = ST_OK;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_BUSY;
      end
      S_BUSY: begin
        // Unknown ids spend one select-less
        // cycle here so every ack lands >= E1.
        if (unk_q) begin
          fin    = 1'b1;
          fin_st = ST_UNK;
        end else if (!blk) begin
          fin    = 1'b1;
        end else if (hit) begin
          fin    = 1'b1;
        end else if (i_abort) begin
          fin    = 1'b1;
          fin_st = ST_ABORT;
        end else if (tmo_q != '0
                     && el_inc == tmo_q) begin
          fin    = 1'b1;
          fin_st = ST_TMO;
        end
        if (fin) state_d = S_ACK;
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= '0;
      tmo_q     <= '0;
      elapsed_q <= '0;
      unk_q     <= 1'b0;
      ack_q     <= 1'b0;
      status_q  <= ST_OK;
      oel_q     <= '0;
      cnt_q     <= '0;
    end else begin
      ack_q <= 1'b0;
      if (accept) begin
        sel_q     <= id_sel;
        tmo_q     <= cmd.i_cmd_timeout;
        elapsed_q <= '0;
        unk_q     <= id_unk;
      end
      if (state_q == S_BUSY) begin
        elapsed_q <= el_inc;
        if (fin) begin
          sel_q    <= '0;
          ack_q    <= 1'b1;
          status_q <= fin_st;
          oel_q    <= unk_q ? '0 : el_inc;
          cnt_q    <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign o_sel     = sel_q;
  assign o_ack     = ack_q;
  assign o_status  = status_q;
  assign o_elapsed = oel_q;
  assign o_cmd_cnt = cnt_q;

endmodule

// File: tb/tb_tb_cmd_dispatcher.sv
// Self-checking bench for tb_cmd_dispatcher: vector table,
// reset/wrap sequences and random commands vs. a rule model.
module tb_tb_cmd_dispatcher;

  localparam int NONE = 1 << 30;
  localparam logic [3:0] BLK = 4'b1010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  i_done;
  logic        i_abort;
  logic [3:0]  o_sel;
  logic        o_ack;
  logic [1:0]  o_status;
  logic [15:0] o_elapsed;
  logic [7:0]  o_cmd_cnt;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_cnt;

  tb_cmd_dispatcher_if #(
    .ID_W(3), .TIMEOUT_W(16)
  ) cif ();

  tb_cmd_dispatcher #(
    .CMD_NB(4), .ID_W(3), .TIMEOUT_W(16),
    .BLOCKING_MASK(4'b1010), .CNT_W(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd       (cif),
    .i_done    (i_done),
    .i_abort   (i_abort),
    .o_sel     (o_sel),
    .o_ack     (o_ack),
    .o_status  (o_status),
    .o_elapsed (o_elapsed),
    .o_cmd_cnt (o_cmd_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  id;
    logic [15:0] tmo;
    int          dk;
    int          ak;
    logic [1:0]  es;
    int          ee;
    int          el;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm,
                     input longint act,
                     input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d",
               nm, act, req);
    end
  endtask

  // Outcome from the rules: first terminating
  // event wins, done > abort > timeout on ties.
  task automatic model(input logic [2:0] id,
                       input logic [15:0] tmo,
                       input int dk, input int ak,
                       output logic [1:0] es,
                       output int ee, output int el);
    int tt, e;
    if (id >= 3'd4) begin
      es = 2'b11; ee = 0; el = 1;
    end else if (!BLK[id]) begin
      es = 2'b00; ee = 1; el = 1;
    end else begin
      tt = (tmo == 16'd0) ? NONE : int'(tmo);
      e = dk;
      if (ak < e) e = ak;
      if (tt < e) e = tt;
      if (dk == e)      es = 2'b00;
      else if (ak == e) es = 2'b10;
      else              es = 2'b01;
      ee = e; el = e;
    end
  endtask

  task automatic run_cmd(input logic [2:0] id,
                         input logic [15:0] tmo,
                         input int dk, input int ak,
                         input logic [1:0] es,
                         input int ee, input int el,
                         input string nm);
    logic [3:0] xs;
    int lat;
    bit sel_ok, rdy_ok;
    xs = (id < 3'd4) ? (4'b0001 << id) : 4'b0000;
    chk({nm, ".ready_idle"}, o_cmd_ready_v(), 1);
    cif.i_cmd_valid   = 1'b1;
    cif.i_cmd_id      = id;
    cif.i_cmd_timeout = tmo;
    @(posedge clk); #1;
    cif.i_cmd_valid   = 1'b0;
    cif.i_cmd_id      = 3'($urandom);
    cif.i_cmd_timeout = 16'($urandom);
    lat = 0; sel_ok = 1; rdy_ok = 1;
    for (int c = 1; c <= el + 20; c++) begin
      if (o_sel !== xs) sel_ok = 0;
      if (cif.o_cmd_ready !== 1'b0) rdy_ok = 0;
      i_done  = (4'($urandom) & ~xs)
              | ((c >= dk) ? xs : 4'b0000);
      i_abort = (c == ak);
      @(posedge clk); #1;
      if (o_ack === 1'b1) begin
        lat = c;
        break;
      end
    end
    i_done = 4'b0; i_abort = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    chk({nm, ".latency"}, lat, el);
    chk({nm, ".status"}, o_status, es);
    chk({nm, ".elapsed"}, o_elapsed, ee);
    chk({nm, ".cnt"}, o_cmd_cnt, exp_cnt);
    chk({nm, ".sel_ack"}, o_sel, 0);
    chk({nm, ".sel_busy"}, sel_ok, 1);
    chk({nm, ".ready_busy"}, rdy_ok, 1);
    @(posedge clk); #1;
    chk({nm, ".ack_1cyc"}, o_ack, 0);
    chk({nm, ".ready_after"}, cif.o_cmd_ready, 1);
    chk({nm, ".status_hold"}, o_status, es);
    chk({nm, ".elapsed_hold"}, o_elapsed, ee);
  endtask

  function automatic logic o_cmd_ready_v();
    return cif.o_cmd_ready;
  endfunction

  initial begin
    logic [2:0]  rid;
    logic [15:0] rtmo;
    int          rdk, rak, ree, rel;
    logic [1:0]  res;
    int          acks, last, c255;
    bit          gap_ok, rdy_ok, seen;

    tbl[0]  = '{3'd0, 16'd0,   NONE, NONE, 2'b00, 1, 1};
    tbl[1]  = '{3'd1, 16'd100, 5,    NONE, 2'b00, 5, 5};
    tbl[2]  = '{3'd3, 16'd10,  10,   NONE, 2'b00, 10, 10};
    tbl[3]  = '{3'd3, 16'd10,  NONE, NONE, 2'b01, 10, 10};
    tbl[4]  = '{3'd1, 16'd0,   NONE, 3,    2'b10, 3, 3};
    tbl[5]  = '{3'd7, 16'd0,   NONE, NONE, 2'b11, 0, 1};
    tbl[6]  = '{3'd2, 16'd5,   NONE, 1,    2'b00, 1, 1};
    tbl[7]  = '{3'd3, 16'd0,   1,    NONE, 2'b00, 1, 1};
    tbl[8]  = '{3'd1, 16'd1,   NONE, NONE, 2'b01, 1, 1};
    tbl[9]  = '{3'd1, 16'd0,   4,    4,    2'b00, 4, 4};
    tbl[10] = '{3'd3, 16'd5,   NONE, 5,    2'b10, 5, 5};
    tbl[11] = '{3'd3, 16'd0,   NONE, 1001, 2'b10,
                1001, 1001};
    tbl[12] = '{3'd4, 16'd3,   1,    NONE, 2'b11, 0, 1};

    rst_n = 1'b0;
    i_done = 4'b0; i_abort = 1'b0;
    cif.i_cmd_valid = 1'b0;
    cif.i_cmd_id = 3'd0;
    cif.i_cmd_timeout = 16'd0;
    exp_cnt = 8'd0;
    #3;
    chk("rst.sel", o_sel, 0);
    chk("rst.ack", o_ack, 0);
    chk("rst.status", o_status, 0);
    chk("rst.elapsed", o_elapsed, 0);
    chk("rst.cnt", o_cmd_cnt, 0);
    chk("rst.ready", cif.o_cmd_ready, 1);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i])
      run_cmd(tbl[i].id, tbl[i].tmo, tbl[i].dk,
              tbl[i].ak, tbl[i].es, tbl[i].ee,
              tbl[i].el, $sformatf("vec%0d", i));

    // Reset while channel 1 is busy.
    cif.i_cmd_valid = 1'b1;
    cif.i_cmd_id = 3'd1;
    cif.i_cmd_timeout = 16'd0;
    @(posedge clk); #1;
    cif.i_cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("midrst.sel_before", o_sel, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.sel", o_sel, 0);
    chk("midrst.ack", o_ack, 0);
    chk("midrst.cnt", o_cmd_cnt, 0);
    chk("midrst.ready", cif.o_cmd_ready, 1);
    exp_cnt = 8'd0;
    #3 rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (o_ack !== 1'b0) seen = 1;
    end
    chk("midrst.no_ack", seen, 0);
    chk("midrst.ready_after", cif.o_cmd_ready, 1);

    // 256 back-to-back non-blocking commands.
    cif.i_cmd_valid = 1'b1;
    cif.i_cmd_id = 3'd2;
    cif.i_cmd_timeout = 16'd0;
    acks = 0; last = -1; c255 = -1;
    gap_ok = 1; rdy_ok = 1;
    for (int c = 1; c <= 767; c++) begin
      @(posedge clk); #1;
      if (o_ack === 1'b1) begin
        if (last >= 0 && c - last != 3) gap_ok = 0;
        last = c;
        acks++;
        if (acks == 255) c255 = int'(o_cmd_cnt);
      end
      if ((o_ack || o_sel != 4'b0)
          && cif.o_cmd_ready) rdy_ok = 0;
      if (!o_ack && o_sel == 4'b0
          && !cif.o_cmd_ready) rdy_ok = 0;
    end
    cif.i_cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("wrap.acks", acks, 256);
    chk("wrap.cnt255", c255, 255);
    chk("wrap.cnt", o_cmd_cnt, 0);
    chk("wrap.period3", gap_ok, 1);
    chk("wrap.ready_pat", rdy_ok, 1);
    chk("wrap.no_extra", o_sel, 0);
    chk("wrap.ready_end", cif.o_cmd_ready, 1);

    for (int n = 0; n < 40; n++) begin
      rid = ($urandom_range(0, 9) < 8)
          ? 3'($urandom_range(0, 3))
          : 3'($urandom_range(4, 7));
      rtmo = ($urandom_range(0, 2) == 0) ? 16'd0
           : 16'($urandom_range(1, 20));
      rdk = $urandom_range(0, 1)
          ? int'($urandom_range(1, 25)) : NONE;
      rak = $urandom_range(0, 1)
          ? int'($urandom_range(1, 25)) : NONE;
      if (rtmo == 16'd0 && rdk == NONE && rak == NONE)
        rak = 30;
      model(rid, rtmo, rdk, rak, res, ree, rel);
      run_cmd(rid, rtmo, rdk, rak, res, ree, rel,
              $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
